// File: rtl/gsensor_spi_slave_pkg.sv
// Shared definitions for the accelerometer stand-in: register addresses,
// STATUS/CTRL bit positions and the SPI frame FSM states.
package gsensor_pkg;

    localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
    localparam logic [5:0] ADDR_CTRL1    = 6'h20;
    localparam logic [5:0] ADDR_CTRL3    = 6'h22;
    localparam logic [5:0] ADDR_STATUS   = 6'h27;
    localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
    localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

    localparam int STATUS_ZYXDA  = 3;
    localparam int STATUS_ZYXOR  = 7;
    localparam int CTRL3_I1_DRDY = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } spi_state_e;

    function automatic logic is_out_addr(input logic [5:0] a);
        return (a >= ADDR_OUT_X_L) && (a <= ADDR_OUT_Z_H);
    endfunction

endpackage

// File: rtl/gsensor_spi_slave_if.sv
// Pin-level bundle between the G-sensor SPI master side and the slave model,
// including the sample injection and write-observation ports.
interface gsensor_spi_slave_if;
    logic        CS;
    logic        SCLK;
    logic        DIN;
    logic        DO;
    logic        DO_OE;
    logic        INT1;
    logic        SAMPLE_VALID;
    logic [15:0] SAMPLE_X;
    logic [15:0] SAMPLE_Y;
    logic [15:0] SAMPLE_Z;
    logic        WR_STB;
    logic [5:0]  WR_ADDR;
    logic [7:0]  WR_DATA;

    modport slave (
        input  CS, SCLK, DIN, SAMPLE_VALID, SAMPLE_X, SAMPLE_Y, SAMPLE_Z,
        output DO, DO_OE, INT1, WR_STB, WR_ADDR, WR_DATA
    );

    modport master (
        output CS, SCLK, DIN, SAMPLE_VALID, SAMPLE_X, SAMPLE_Y, SAMPLE_Z,
        input  DO, DO_OE, INT1, WR_STB, WR_ADDR, WR_DATA
    );
endinterface

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with a history flop so
// rise/fall are single-cycle pulses on the synchronized copy.
module spi_in_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= {3{RST_VAL}};
        else        sync_pipe <= {sync_pipe[1:0], pin};
    end

    assign sync = sync_pipe[1];
    assign rise = sync_pipe[1] & ~sync_pipe[2];
    assign fall = ~sync_pipe[1] & sync_pipe[2];
endmodule

// File: rtl/gsensor_spi_slave.sv
// SPI mode-3 slave emulating the accelerometer: register file, injected X/Y/Z
// samples with block-data-update protection, and a data-ready INT1.
module gsensor_spi_slave
    import gsensor_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
    parameter logic [7:0] CTRL1_RST    = 8'h07
) (
    input  logic SYS_CLK,
    input  logic RESET_N,
    gsensor_spi_slave_if.slave bus
);
    localparam int NUM_PINS = 3;
    localparam int PIN_CS   = 0;
    localparam int PIN_SCLK = 1;
    localparam int PIN_DIN  = 2;

    logic [NUM_PINS-1:0] pin_raw, pin_s, pin_rise, pin_fall;
    assign pin_raw = {bus.DIN, bus.SCLK, bus.CS};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
        spi_in_sync u_sync (
            .clk   (SYS_CLK),
            .rst_n (RESET_N),
            .pin   (pin_raw[i]),
            .sync  (pin_s[i]),
            .rise  (pin_rise[i]),
            .fall  (pin_fall[i])
        );
    end

    logic cs_s, cs_rise, cs_fall, sclk_rise, sclk_fall, din_s;
    assign cs_s      = pin_s[PIN_CS];
    assign cs_rise   = pin_rise[PIN_CS];
    assign cs_fall   = pin_fall[PIN_CS];
    assign sclk_rise = pin_rise[PIN_SCLK];
    assign sclk_fall = pin_fall[PIN_SCLK];
    assign din_s     = pin_s[PIN_DIN];

    logic unused_ok;
    assign unused_ok = &{1'b0, pin_s[PIN_SCLK], pin_rise[PIN_DIN], pin_fall[PIN_DIN]};

    // frame state
    spi_state_e      state, state_nxt;
    logic            bit_tick, cmd_done, data_done, shift_out;
    logic [2:0]      bit_cnt;
    logic [6:0]      rx_sr;
    logic [7:0]      tx_sr;
    logic            rw, ms, touched, do_q;
    logic [5:0]      addr;

    // register file
    logic [7:0]      ctrl1, ctrl3;
    logic [5:0][7:0] out_r, pend_s, sample_in;
    logic            zyxda, zyxor, pend_v, int1_q;
    logic            wr_stb_q;
    logic [5:0]      wr_addr_q;
    logic [7:0]      wr_data_q;

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bit_tick  = 1'b0;
        cmd_done  = 1'b0;
        data_done = 1'b0;
        shift_out = 1'b0;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                bit_tick = sclk_rise;
                cmd_done = sclk_rise && (bit_cnt == 3'd7);
                if (cmd_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                bit_tick  = sclk_rise;
                data_done = sclk_rise && (bit_cnt == 3'd7);
                shift_out = sclk_fall && rw;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // CS release aborts whatever byte is in flight
        if (cs_rise) begin
            state_nxt = ST_IDLE;
            bit_tick  = 1'b0;
            cmd_done  = 1'b0;
            data_done = 1'b0;
            shift_out = 1'b0;
        end
    end

    logic [7:0] rx_byte, rd_data;
    logic [5:0] ld_addr;
    logic       ld_en, ld_rw, touch_now, wr_en, clr_st, hold, apply;

    assign rx_byte   = {rx_sr, din_s};
    assign ld_en     = cmd_done | data_done;
    assign ld_addr   = cmd_done ? rx_byte[5:0] : (ms ? addr + 6'd1 : addr);
    assign ld_rw     = cmd_done ? rx_byte[7] : rw;
    assign touch_now = ld_en & ld_rw & is_out_addr(ld_addr);
    assign wr_en     = data_done & ~rw;
    assign clr_st    = data_done & rw & (addr == ADDR_OUT_Z_H);
    assign hold      = touched | touch_now;
    assign apply     = ~hold & (bus.SAMPLE_VALID | pend_v);
    assign sample_in = {bus.SAMPLE_Z, bus.SAMPLE_Y, bus.SAMPLE_X};

    always_comb begin
        rd_data = 8'h00;
        case (ld_addr)
            ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
            ADDR_CTRL1:    rd_data = ctrl1;
            ADDR_CTRL3:    rd_data = ctrl3;
            ADDR_STATUS: begin
                rd_data[STATUS_ZYXDA] = zyxda;
                rd_data[STATUS_ZYXOR] = zyxor;
            end
            default: if (is_out_addr(ld_addr)) rd_data = out_r[ld_addr[2:0]];
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rw        <= 1'b0;
            ms        <= 1'b0;
            addr      <= '0;
            touched   <= 1'b0;
            do_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            if (cs_fall) begin
                bit_cnt <= '0;
                do_q    <= 1'b0;
            end
            if (bit_tick) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (cmd_done) begin
                rw <= rx_byte[7];
                ms <= rx_byte[6];
            end
            // tx reload happens on the last rise so the MSB leaves on the next fall
            if (ld_en) begin
                addr  <= ld_addr;
                tx_sr <= rd_data;
            end
            if (shift_out) begin
                do_q  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (wr_en) begin
                wr_stb_q  <= 1'b1;
                wr_addr_q <= addr;
                wr_data_q <= rx_byte;
            end
            if (touch_now)    touched <= 1'b1;
            else if (cs_rise) touched <= 1'b0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl1  <= CTRL1_RST;
            ctrl3  <= '0;
            out_r  <= '0;
            pend_s <= '0;
            pend_v <= 1'b0;
            zyxda  <= 1'b0;
            zyxor  <= 1'b0;
            int1_q <= 1'b0;
        end else begin
            int1_q <= zyxda & ctrl3[CTRL3_I1_DRDY];
            if (wr_en && addr == ADDR_CTRL1) ctrl1 <= rx_byte;
            if (wr_en && addr == ADDR_CTRL3) ctrl3 <= rx_byte;
            // a live strobe is newer than anything parked, so it wins
            if (apply) begin
                out_r  <= bus.SAMPLE_VALID ? sample_in : pend_s;
                pend_v <= 1'b0;
                zyxda  <= 1'b1;
                zyxor  <= (~clr_st & (zyxor | zyxda)) | (bus.SAMPLE_VALID & pend_v);
            end else begin
                if (clr_st) begin
                    zyxda <= 1'b0;
                    zyxor <= 1'b0;
                end
                if (bus.SAMPLE_VALID) begin
                    pend_v <= 1'b1;
                    pend_s <= sample_in;
                end
            end
        end
    end

    assign bus.DO_OE   = ~cs_s;
    assign bus.DO      = do_q & ~cs_s;
    assign bus.INT1    = int1_q;
    assign bus.WR_STB  = wr_stb_q;
    assign bus.WR_ADDR = wr_addr_q;
    assign bus.WR_DATA = wr_data_q;
endmodule

// File: tb/tb_gsensor_spi_slave.sv
// Scoreboard bench for gsensor_spi_slave: a mode-3 SPI master task, expected
// read bytes and write strobes queued at stimulus time and popped on output.
module tb_gsensor_spi_slave;
    import gsensor_pkg::*;

    localparam int HALF = 6;

    logic SYS_CLK;
    logic RESET_N;
    gsensor_spi_slave_if bus();

    gsensor_spi_slave #(
        .WHO_AM_I_VAL (8'h33),
        .CTRL1_RST    (8'h07)
    ) dut (
        .SYS_CLK (SYS_CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mosi_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [13:0] exp_wr_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge SYS_CLK);
    endtask

    // every write strobe must match the oldest queued write
    always @(negedge SYS_CLK) begin
        if (RESET_N && bus.WR_STB === 1'b1) begin
            if (exp_wr_q.size() == 0) chk("wr_strobe_unexpected", bus.WR_STB, 0);
            else chk("wr_addr_data", {bus.WR_ADDR, bus.WR_DATA}, exp_wr_q.pop_front());
        end
    end

    task automatic frame(input int cut_bits, input int sv_byte);
        logic [7:0] b, got;
        logic       rd;
        int         nbits;
        rd = mosi_q[0][7];
        bus.SCLK = 1'b1;
        bus.CS   = 1'b0;
        wait_clk(4);
        chk("do_oe_active", bus.DO_OE, 1);
        for (int i = 0; i < mosi_q.size(); i++) begin
            b     = mosi_q[i];
            got   = '0;
            nbits = (i == mosi_q.size() - 1 && cut_bits > 0) ? cut_bits : 8;
            for (int j = 0; j < nbits; j++) begin
                bus.SCLK = 1'b0;
                bus.DIN  = b[7-j];
                wait_clk(HALF);
                got[7-j] = bus.DO;
                bus.SCLK = 1'b1;
                wait_clk(HALF);
            end
            if (i == sv_byte) begin
                bus.SAMPLE_VALID = 1'b1;
                wait_clk(1);
                bus.SAMPLE_VALID = 1'b0;
            end
            if (rd && i > 0 && nbits == 8 && exp_rd_q.size() > 0)
                chk("rd_byte", got, exp_rd_q.pop_front());
        end
        wait_clk(2);
        bus.CS  = 1'b1;
        bus.DIN = 1'b0;
        wait_clk(10);
        mosi_q.delete();
    endtask

    task automatic rd1(input logic [5:0] a, input logic [7:0] e);
        mosi_q = '{{2'b10, a}, 8'h00};
        exp_rd_q.push_back(e);
        frame(0, -1);
    endtask

    task automatic wr1(input logic [5:0] a, input logic [7:0] d);
        mosi_q = '{{2'b00, a}, d};
        exp_wr_q.push_back({a, d});
        frame(0, -1);
    endtask

    task automatic set_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        bus.SAMPLE_X = x;
        bus.SAMPLE_Y = y;
        bus.SAMPLE_Z = z;
    endtask

    task automatic pulse_sample();
        bus.SAMPLE_VALID = 1'b1;
        wait_clk(1);
        bus.SAMPLE_VALID = 1'b0;
    endtask

    // burst read from OUT_X_L with auto-increment; expected bytes are little-endian per axis
    task automatic burst(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input int sv_byte);
        logic [47:0] s;
        s = {z, y, x};
        mosi_q = '{8'hE8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 6; k++) exp_rd_q.push_back(s[8*k +: 8]);
        frame(0, sv_byte);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N          = 1'b0;
        bus.CS           = 1'b1;
        bus.SCLK         = 1'b1;
        bus.DIN          = 1'b0;
        bus.SAMPLE_VALID = 1'b0;
        set_sample(16'h0, 16'h0, 16'h0);
        wait_clk(3);
        chk("rst_do",      bus.DO,      0);
        chk("rst_do_oe",   bus.DO_OE,   0);
        chk("rst_int1",    bus.INT1,    0);
        chk("rst_wr_stb",  bus.WR_STB,  0);
        chk("rst_wr_addr", bus.WR_ADDR, 0);
        chk("rst_wr_data", bus.WR_DATA, 0);
        RESET_N = 1'b1;
        wait_clk(4);

        rd1(ADDR_WHO_AM_I, 8'h33);
        wr1(ADDR_CTRL1, 8'h57);
        rd1(ADDR_CTRL1, 8'h57);
        wr1(ADDR_CTRL3, 8'h10);

        set_sample(16'h1234, 16'hABCD, 16'h8001);
        pulse_sample();
        wait_clk(4);
        chk("int1_after_sample", bus.INT1, 1);
        burst(16'h1234, 16'hABCD, 16'h8001, -1);
        chk("int1_after_zh_read", bus.INT1, 0);
        rd1(ADDR_STATUS, 8'h00);

        set_sample(16'h0102, 16'h0304, 16'h0506);
        pulse_sample();
        wait_clk(3);
        set_sample(16'h7F10, 16'h8020, 16'hFFFE);
        pulse_sample();
        wait_clk(4);
        rd1(ADDR_STATUS, 8'h88);
        burst(16'h7F10, 16'h8020, 16'hFFFE, -1);
        rd1(ADDR_STATUS, 8'h00);

        // new sample lands mid-burst: this frame keeps the old set
        set_sample(16'h4455, 16'h6677, 16'h0A0B);
        burst(16'h7F10, 16'h8020, 16'hFFFE, 2);
        chk("int1_held_sample_applied", bus.INT1, 1);
        rd1(ADDR_STATUS, 8'h08);
        burst(16'h4455, 16'h6677, 16'h0A0B, -1);
        chk("int1_after_new_read", bus.INT1, 0);

        mosi_q = '{8'h7F, 8'h11, 8'h22};
        exp_wr_q.push_back({6'h3F, 8'h11});
        exp_wr_q.push_back({6'h00, 8'h22});
        frame(0, -1);

        wr1(ADDR_WHO_AM_I, 8'hAA);
        rd1(ADDR_WHO_AM_I, 8'h33);

        mosi_q = '{8'h20, 8'hFF};
        frame(5, -1);
        rd1(ADDR_CTRL1, 8'h57);

        set_sample(16'h1357, 16'h2468, 16'h9BDF);
        pulse_sample();
        wait_clk(4);
        chk("int1_pre_reset", bus.INT1, 1);

        bus.CS = 1'b0;
        wait_clk(6);
        chk("do_oe_pre_reset", bus.DO_OE, 1);
        @(negedge SYS_CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midrst_do_oe",   bus.DO_OE,   0);
        chk("midrst_do",      bus.DO,      0);
        chk("midrst_int1",    bus.INT1,    0);
        chk("midrst_wr_stb",  bus.WR_STB,  0);
        chk("midrst_wr_addr", bus.WR_ADDR, 0);
        chk("midrst_wr_data", bus.WR_DATA, 0);
        bus.CS = 1'b1;
        wait_clk(3);
        RESET_N = 1'b1;
        wait_clk(4);

        rd1(ADDR_CTRL1,  8'h07);
        rd1(ADDR_CTRL3,  8'h00);
        rd1(ADDR_STATUS, 8'h00);

        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("wr_queue_drained", exp_wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
